// File: rtl/cnt_tk1_schedule.sv
// rtl/cnt_tk1_schedule.sv - Romulus-N block counter LFSR and TK1 round tweakey streamer.
// Optional sticky counter-wrap detection is built when CNT_TK1_WRAP_EN is defined.
module cnt_tk1_schedule #(
  parameter int ROUNDS = 40,
  parameter int UNROLL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cnt_load,
  input  logic [55:0]           cnt_in,
  input  logic                  cnt_init,
  input  logic                  cnt_inc,
  output logic [55:0]           cnt_out,
  input  logic [7:0]            domain,
  input  logic                  start,
  output logic                  ready,
  output logic [64*UNROLL-1:0]  rtk,
  output logic                  rtk_valid,
  input  logic                  rtk_ready,
  output logic                  rtk_last,
  output logic                  cnt_wrap
);

  localparam int IDXW = $clog2(ROUNDS + 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [127:0]    tk_q, tk_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [55:0]     cnt_q, cnt_d, cnt_step;
  logic            start_ok, start_acc, last_idx;
  logic [127:0]    stage [UNROLL+1];
  logic [127:0]    tk_init;
  logic [64*UNROLL-1:0] rtk_all;

  // new[i] = old[P[i]], P = 9,15,8,13,10,14,12,11,0..7; byte 0 sits at [127:120]
  function automatic logic [127:0] pt(input logic [127:0] s);
    pt = {s[55:48], s[7:0], s[63:56], s[23:16], s[47:40], s[15:8], s[31:24], s[39:32],
          s[127:64]};
  endfunction

  function automatic logic [55:0] lfsr_step(input logic [55:0] c);
    lfsr_step = {c[54:0], 1'b0} ^ (c[55] ? 56'h95 : 56'h0);
  endfunction

`ifdef CNT_TK1_WRAP_EN
  logic wrap_q, wrap_d;
  assign start_ok = !wrap_q;
  assign cnt_wrap = wrap_q;
`else
  assign start_ok = 1'b1;
  assign cnt_wrap = 1'b0;
`endif

  assign start_acc = (state_q == S_IDLE) && start_ok && start;
  assign last_idx  = (idx_q == IDXW'(ROUNDS - UNROLL));

  always_comb begin
    stage[0] = tk_q;
    for (int k = 0; k < UNROLL; k++) stage[k+1] = pt(stage[k]);
    rtk_all = '0;
    for (int k = 0; k < UNROLL; k++) rtk_all[64*(UNROLL-k)-1 -: 64] = stage[k][127:64];
  end

  always_comb begin
    tk_init = '0;
    for (int i = 0; i < 7; i++) tk_init[127-8*i -: 8] = cnt_q[8*i +: 8];
    tk_init[71:64] = domain;
  end

  // Counter commands only act in IDLE; a same-cycle start already captured the old value
  always_comb begin
    cnt_d    = cnt_q;
    cnt_step = lfsr_step(cnt_q);
`ifdef CNT_TK1_WRAP_EN
    wrap_d   = wrap_q;
`endif
    if (state_q == S_IDLE) begin
      if (cnt_load) begin
        cnt_d = cnt_in;
`ifdef CNT_TK1_WRAP_EN
        wrap_d = 1'b0;
`endif
      end else if (cnt_init) begin
        cnt_d = 56'h1;
`ifdef CNT_TK1_WRAP_EN
        wrap_d = 1'b0;
`endif
      end else if (cnt_inc) begin
        cnt_d = cnt_step;
`ifdef CNT_TK1_WRAP_EN
        if (cnt_step == 56'h1) wrap_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tk_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= 56'h1;
`ifdef CNT_TK1_WRAP_EN
      wrap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tk_q    <= tk_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
`ifdef CNT_TK1_WRAP_EN
      wrap_q  <= wrap_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tk_d    = tk_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          tk_d    = tk_init;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (rtk_ready) begin
          tk_d  = stage[UNROLL];
          idx_d = idx_q + IDXW'(UNROLL);
          if (last_idx) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state_q == S_IDLE) && start_ok;
    rtk_valid = (state_q == S_RUN);
    rtk_last  = (state_q == S_RUN) && last_idx;
    rtk       = (state_q == S_RUN) ? rtk_all : '0;
    cnt_out   = cnt_q;
  end

endmodule

// File: tb/tb_cnt_tk1_schedule.sv
// tb/tb_cnt_tk1_schedule.sv - Randomised and directed bench for cnt_tk1_schedule with UNROLL 1 and 4.
module tb_cnt_tk1_schedule;
  localparam int ROUNDS = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cnt_load, cnt_init, cnt_inc, start, rtk_ready1, rtk_ready4;
  logic [55:0] cnt_in;
  logic [7:0]  domain;
  logic [55:0] cnt_out1, cnt_out4;
  logic        ready1, ready4, rtk_valid1, rtk_valid4, rtk_last1, rtk_last4, cnt_wrap1, cnt_wrap4;
  logic [63:0]  rtk1;
  logic [255:0] rtk4;

  cnt_tk1_schedule #(.ROUNDS(ROUNDS), .UNROLL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .cnt_load(cnt_load), .cnt_in(cnt_in), .cnt_init(cnt_init),
    .cnt_inc(cnt_inc), .cnt_out(cnt_out1), .domain(domain), .start(start), .ready(ready1),
    .rtk(rtk1), .rtk_valid(rtk_valid1), .rtk_ready(rtk_ready1), .rtk_last(rtk_last1),
    .cnt_wrap(cnt_wrap1));

  cnt_tk1_schedule #(.ROUNDS(ROUNDS), .UNROLL(4)) u4 (
    .clk(clk), .rst_n(rst_n), .cnt_load(cnt_load), .cnt_in(cnt_in), .cnt_init(cnt_init),
    .cnt_inc(cnt_inc), .cnt_out(cnt_out4), .domain(domain), .start(start), .ready(ready4),
    .rtk(rtk4), .rtk_valid(rtk_valid4), .rtk_ready(rtk_ready4), .rtk_last(rtk_last4),
    .cnt_wrap(cnt_wrap4));

  int vecs = 0;
  int errs = 0;

  // Reference: per instance, busy flag, round pointer, counter, wrap flag and the block's round list
  logic        m_busy [2];
  int          m_idx  [2];
  logic [55:0] m_cnt  [2];
  logic        m_wrap [2];
  logic [63:0] m_rnd  [2][ROUNDS];
  int          perm   [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0; m_idx[d] = 0; m_cnt[d] = 56'h1; m_wrap[d] = 1'b0;
    end
  endtask

  task automatic build(input int d, input logic [55:0] c, input logic [7:0] dom);
    logic [7:0]  b [16];
    logic [7:0]  t [16];
    logic [63:0] w;
    for (int i = 0; i < 16; i++) b[i] = 8'h0;
    for (int i = 0; i < 7; i++) b[i] = c[8*i +: 8];
    b[7] = dom;
    for (int r = 0; r < ROUNDS; r++) begin
      w = 64'h0;
      for (int i = 0; i < 8; i++) w = {w[55:0], b[i]};
      m_rnd[d][r] = w;
      for (int i = 0; i < 16; i++) t[i] = b[perm[i]];
      for (int i = 0; i < 16; i++) b[i] = t[i];
    end
  endtask

  task automatic model_step();
    logic [56:0] sh;
    int          u;
    logic        rdy;
    if (!rst_n) return;
    for (int d = 0; d < 2; d++) begin
      u   = (d == 0) ? 1 : 4;
      rdy = (d == 0) ? rtk_ready1 : rtk_ready4;
      if (!m_busy[d]) begin
        if (start && !m_wrap[d]) begin
          build(d, m_cnt[d], domain);
          m_busy[d] = 1'b1;
          m_idx[d]  = 0;
        end
        if (cnt_load) begin
          m_cnt[d] = cnt_in; m_wrap[d] = 1'b0;
        end else if (cnt_init) begin
          m_cnt[d] = 56'h1; m_wrap[d] = 1'b0;
        end else if (cnt_inc) begin
          sh = {m_cnt[d], 1'b0};
          if (sh[56]) sh = sh ^ 57'h100000000000095;
          m_cnt[d] = sh[55:0];
`ifdef CNT_TK1_WRAP_EN
          if (m_cnt[d] == 56'h1) m_wrap[d] = 1'b1;
`endif
        end
      end else if (rdy) begin
        m_idx[d] = m_idx[d] + u;
        if (m_idx[d] >= ROUNDS) m_busy[d] = 1'b0;
      end
    end
  endtask

  function automatic logic [255:0] exp_rtk(input int d);
    logic [255:0] w;
    int u;
    u = (d == 0) ? 1 : 4;
    w = '0;
    if (m_busy[d])
      for (int k = 0; k < u; k++) w = {w[191:0], m_rnd[d][m_idx[d]+k]};
    return w;
  endfunction

  task automatic check_all();
    chk("ready1", ready1, !m_busy[0] && !m_wrap[0]);
    chk("valid1", rtk_valid1, m_busy[0]);
    chk("last1",  rtk_last1, m_busy[0] && m_idx[0] == ROUNDS - 1);
    chk("rtk1",   rtk1, exp_rtk(0));
    chk("cnt1",   cnt_out1, m_cnt[0]);
    chk("wrap1",  cnt_wrap1, m_wrap[0]);
    chk("ready4", ready4, !m_busy[1] && !m_wrap[1]);
    chk("valid4", rtk_valid4, m_busy[1]);
    chk("last4",  rtk_last4, m_busy[1] && m_idx[1] == ROUNDS - 4);
    chk("rtk4",   rtk4, exp_rtk(1));
    chk("cnt4",   cnt_out4, m_cnt[1]);
    chk("wrap4",  cnt_wrap4, m_wrap[1]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_in();
    cnt_load = 1'b0; cnt_init = 1'b0; cnt_inc = 1'b0; start = 1'b0;
  endtask

  initial begin
    int n1, n4, bound;
    logic [63:0] r64;
    rst_n = 1'b0; idle_in(); cnt_in = '0; domain = '0; rtk_ready1 = 1'b1; rtk_ready4 = 1'b1;
    model_reset();
    @(negedge clk);
    check_all();
    chk("rst_cnt_lit", cnt_out1, 56'h1);
    rst_n = 1'b1;

    cnt_inc = 1'b1; cyc(); idle_in();
    chk("inc_lit", cnt_out1, 56'h2);
    cnt_load = 1'b1; cnt_in = 56'h80000000000000; cyc(); idle_in();
    cnt_inc = 1'b1; cyc(); idle_in();
    chk("inc_top_lit", cnt_out1, 56'h95);

    cnt_load = 1'b1; cnt_in = 56'h07060504030201; cyc(); idle_in();
    start = 1'b1; domain = 8'h08; cyc(); idle_in();
    chk("r0_lit",  m_rnd[0][0], 64'h0102030405060708);
    chk("r1_lit",  m_rnd[0][1], 64'h0);
    chk("r2_lit",  m_rnd[0][2], 64'h0208010603070504);
    chk("r16_lit", m_rnd[0][16], 64'h0102030405060708);
    chk("beat0_u1_lit", rtk1, 64'h0102030405060708);
    chk("beat0_u4_lit", rtk4, {64'h0102030405060708, 64'h0, 64'h0208010603070504, 64'h0});
    n1 = 0; n4 = 0;
    for (int i = 0; i < 45; i++) begin
      if (rtk_valid1) n1++;
      if (rtk_valid4) n4++;
      cyc();
    end
    chk("beats_u1", n1, ROUNDS);
    chk("beats_u4", n4, ROUNDS / 4);

    start = 1'b1; cnt_inc = 1'b1; cyc(); idle_in();
    chk("old_cnt_stream", rtk1, 64'h0102030405060708);
    chk("cnt_adv_lit", cnt_out1, 56'h0E0C0A08060402);
    for (int i = 0; i < 3; i++) cyc();
    rtk_ready1 = 1'b0; rtk_ready4 = 1'b0; cnt_inc = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    rtk_ready1 = 1'b1; rtk_ready4 = 1'b1; cnt_inc = 1'b0;
    bound = 0;
    while (m_idx[0] != 5 && bound < 30) begin cyc(); bound++; end
    chk("beat5_reached", m_idx[0], 5);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_mid_valid", rtk_valid1, 1'b0);
    chk("rst_mid_cnt", cnt_out1, 56'h1);
    cyc();
    rst_n = 1'b1;

`ifdef CNT_TK1_WRAP_EN
    cnt_load = 1'b1; cnt_in = 56'h8000000000004A; cyc(); idle_in();
    cnt_inc = 1'b1; cyc(); idle_in();
    chk("wrap_cnt_lit", cnt_out1, 56'h1);
    chk("wrap_set_lit", cnt_wrap1, 1'b1);
    chk("wrap_ready_lit", ready1, 1'b0);
    start = 1'b1; cyc(); idle_in();
    chk("wrap_refused", rtk_valid1, 1'b0);
    cnt_init = 1'b1; cyc(); idle_in();
    chk("wrap_clr_lit", cnt_wrap1, 1'b0);
`endif

    for (int i = 0; i < 1500; i++) begin
      r64 = {$urandom(), $urandom()};
      cnt_in     = r64[55:0];
      domain     = 8'($urandom());
      cnt_load   = ($urandom_range(0, 15) == 0);
      cnt_init   = ($urandom_range(0, 15) == 0);
      cnt_inc    = ($urandom_range(0, 3) == 0);
      rtk_ready1 = ($urandom_range(0, 3) != 0);
      rtk_ready4 = ($urandom_range(0, 3) != 0);
      start      = !m_busy[0] && !m_busy[1] && !m_wrap[0] && !m_wrap[1] &&
                   ($urandom_range(0, 2) == 0);
      cyc();
    end
    idle_in();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
